// File: rtl/ring_arb_pkg.sv
// Shared definitions for the token-ring round-robin arbiter.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ring_arb_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Widest ring the rotate helper supports
    localparam int unsigned VEC_W = 32;

    // Ceiling log2. Returns 0 for v<=1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Rotate the low n bits of v left by one. Bit n-1 wraps into bit 0.
    function automatic logic [VEC_W-1:0] rotl1(input logic [VEC_W-1:0] v, input int unsigned n);
        logic [VEC_W-1:0] mask;
        if (n >= VEC_W) begin
            mask = '1;
        end else begin
            mask = (VEC_W'(1) << n) - VEC_W'(1);
        end
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_token_reg.sv
// One-hot token ring register: holds the current highest-priority position.
// Latency: new token visible one cycle after load.
// Backpressure: none; an invalid (zero or multi-hot) token self-repairs to bit0 on the next edge.
module ring_token_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] next_token,
    output logic [N-1:0] token,
    output logic         token_ok
);

    localparam logic [N-1:0] TOKEN_INIT = {{(N-1){1'b0}}, 1'b1};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    always_comb begin
        token_ok = (token != '0) && ((token & (token - N'(1))) == '0);
    end

    // Token storage with reset preset, corruption repair and advance
    always_ff @(posedge clk) begin
        if (rst) begin
            token <= TOKEN_INIT;
        end else if (!token_ok) begin
            token <= TOKEN_INIT;
        end else if (load) begin
            token <= next_token;
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: search starts at the token bit, grant held until done/req drop/MAX_HOLD.
// Latency: request seen in IDLE at cycle t gives a registered grant from t+1.
// Backpressure: en=0 blocks new grants only; release always forces one idle cycle before the next grant.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDX_W    = (clog2(N) < 1) ? 1 : int'(clog2(N))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     token,
    output logic             timeout
);

    localparam int HC_W = int'(clog2(MAX_HOLD + 1));

    logic [0:0]       state;
    logic [HC_W-1:0]  hold_cnt;
    logic             token_ok;
    logic [IDX_W-1:0] tok_idx;
    logic [N-1:0]     pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             owner_req;
    logic             owner_done;
    logic             hold_exp;
    logic             release_now;
    logic [VEC_W-1:0] rot_full;
    logic [N-1:0]     token_next;

    ring_token_reg #(
        .N (N)
    ) u_token (
        .clk        (clk),
        .rst        (rst),
        .load       (release_now),
        .next_token (token_next),
        .token      (token),
        .token_ok   (token_ok)
    );

    // Binary position of the token, the starting point of the search
    always_comb begin
        tok_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (token[i]) begin
                tok_idx = IDX_W'(i);
            end
        end
    end

    // First requester at or above the token position, wrapping past N-1 to 0
    always_comb begin
        int               p;
        logic [IDX_W-1:0] pi;
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        p        = 0;
        pi       = '0;
        for (int k = 0; k < N; k++) begin
            p = int'(tok_idx) + k;
            if (p >= N) begin
                p = p - N;
            end
            pi = IDX_W'(p);
            if (!pick_vld && req[pi]) begin
                pick_vld = 1'b1;
                pick_idx = pi;
            end
        end
        pick[pick_idx] = pick_vld;
    end

    // Release conditions for the current owner; other requesters are ignored while granted
    always_comb begin
        owner_req   = req[gnt_idx];
        owner_done  = done[gnt_idx];
        hold_exp    = (hold_cnt == HC_W'(MAX_HOLD));
        release_now = (state == ST_GRANT) && (owner_done || !owner_req || hold_exp);
        rot_full    = rotl1(VEC_W'(gnt), $unsigned(N));
        token_next  = rot_full[N-1:0];
    end

    // Grant FSM, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == ST_IDLE) begin
                if (en && pick_vld && token_ok) begin
                    state     <= ST_GRANT;
                    gnt       <= pick;
                    gnt_valid <= 1'b1;
                    gnt_idx   <= pick_idx;
                    hold_cnt  <= HC_W'(1);
                end
            end else begin
                if (release_now) begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    gnt_idx   <= '0;
                    hold_cnt  <= '0;
                    // Expiry is flagged only when the owner neither finished nor withdrew
                    timeout   <= hold_exp && !owner_done && owner_req;
                end else begin
                    hold_cnt <= hold_cnt + HC_W'(1);
                end
            end
        end
    end

endmodule
